// File: rtl/bram_player.sv
// bram_player
//   Multi-channel BRAM waveform player. Plays the address window
//   [start_addr, stop_addr] (modulo 2^ADDR_WIDTH) with each address held for
//   dec_rate+1 cycles, in single, burst (burst_cnt passes) or continuous mode.
//   Playback starts after an arm edge plus an optional trigger. abort returns
//   the player to IDLE at any time. Lanes show default_value whenever no
//   playing sample is in flight.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   arm             : rising edge arms the player
//   trig, trig_sel  : trig_sel=0 starts on arm, trig_sel=1 waits for trig=1
//   abort           : level, back to IDLE, no done
//   mode            : 0 single, 1 burst, 2 continuous, 3 single
//   burst_cnt       : passes in burst mode (0 behaves as 1)
//   dec_rate        : hold count minus one per address
//   start_addr      : first window address
//   stop_addr       : last window address (inclusive)
//   default_value   : per-lane idle level, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   bram_addr/we    : BRAM read port (we tied low)
//   bram_data_i     : packed lanes returned by the BRAM
//   data_o          : registered output lanes
//   sample_stb      : pulse when data_o takes the first sample of an address
//   busy            : ARMED or PLAY
//   done            : pulse on normal completion
//   pass_cnt        : completed passes of the current run
module bram_player #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 14,
  parameter int N_CH       = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       trig,
  input  logic                       trig_sel,
  input  logic                       abort,
  input  logic [1:0]                 mode,
  input  logic [15:0]                burst_cnt,
  input  logic [31:0]                dec_rate,
  input  logic [ADDR_WIDTH-1:0]      start_addr,
  input  logic [ADDR_WIDTH-1:0]      stop_addr,
  input  logic [N_CH*DATA_WIDTH-1:0] default_value,
  output logic [ADDR_WIDTH-1:0]      bram_addr,
  output logic                       bram_we,
  input  logic [N_CH*DATA_WIDTH-1:0] bram_data_i,
  output logic [N_CH*DATA_WIDTH-1:0] data_o,
  output logic                       sample_stb,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                pass_cnt
);

  localparam int LANES_W = N_CH * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PLAY  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                    arm_q, arm_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   start_q, start_d;
  logic [ADDR_WIDTH-1:0]   stop_q, stop_d;
  logic [31:0]             dec_q, dec_d;
  logic [31:0]             hold_q, hold_d;
  logic [15:0]             target_q, target_d;
  logic                    cont_q, cont_d;
  logic [15:0]             pass_cnt_q, pass_cnt_d;
  logic                    done_q, done_d;
  logic [RD_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0]   stb_pipe_q, stb_pipe_d;
  logic [LANES_W-1:0]      data_q, data_d;
  logic                    sample_stb_q, sample_stb_d;

  logic                    arm_rise;
  logic                    go;
  logic                    last_hold;
  logic                    pass_end;
  logic                    final_pass;
  logic                    finish;
  logic                    vld_in;
  logic                    stb_in;
  logic [RD_LATENCY:0]     vld_ext;
  logic [RD_LATENCY:0]     stb_ext;

  // Control decodes shared by next-state and datapath logic.
  always_comb begin
    arm_rise   = arm & ~arm_q;
    go         = (state_q == S_ARMED) && !abort && (!trig_sel || trig);
    last_hold  = (hold_q == dec_q);
    pass_end   = (state_q == S_PLAY) && last_hold && (addr_q == stop_q);
    // pass_cnt_q never exceeds target-1 outside continuous mode, so the
    // 17-bit sum only matters for robustness.
    final_pass = !cont_q &&
                 (({1'b0, pass_cnt_q} + 17'd1) >= {1'b0, target_q});
    finish     = pass_end && final_pass && !abort;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks both trigger and completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (arm_rise) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (abort)   state_d = S_IDLE;
        else if (go) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (abort)       state_d = S_IDLE;
        else if (finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    arm_d      = arm;
    addr_d     = addr_q;
    start_d    = start_q;
    stop_d     = stop_q;
    dec_d      = dec_q;
    hold_d     = hold_q;
    target_d   = target_q;
    cont_d     = cont_q;
    pass_cnt_d = pass_cnt_q;
    done_d     = finish;

    if (go) begin
      // Run configuration is captured once; later input changes are ignored.
      start_d    = start_addr;
      stop_d     = stop_addr;
      dec_d      = dec_rate;
      cont_d     = (mode == 2'd2);
      if (mode == 2'd1) begin
        target_d = (burst_cnt == 16'd0) ? 16'd1 : burst_cnt;
      end else begin
        target_d = 16'd1;
      end
      addr_d     = start_addr;
      hold_d     = '0;
      pass_cnt_d = '0;
    end else if (state_q == S_PLAY) begin
      if (abort) begin
        addr_d = start_q;
        hold_d = '0;
      end else if (last_hold) begin
        hold_d = '0;
        if (addr_q == stop_q) begin
          // Wrap also covers the final pass, leaving bram_addr at start in IDLE.
          addr_d = start_q;
          if (pass_cnt_q != '1) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
          end
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end else begin
        hold_d = hold_q + 32'd1;
      end
    end
  end

  // Valid/strobe delay line aligns each address with its returning BRAM data.
  always_comb begin
    vld_in       = (state_q == S_PLAY);
    stb_in       = (state_q == S_PLAY) && (hold_q == '0);
    vld_ext      = {vld_pipe_q, vld_in};
    stb_ext      = {stb_pipe_q, stb_in};
    vld_pipe_d   = vld_ext[RD_LATENCY-1:0];
    stb_pipe_d   = stb_ext[RD_LATENCY-1:0];
    data_d       = vld_pipe_q[RD_LATENCY-1] ? bram_data_i : default_value;
    sample_stb_d = stb_pipe_q[RD_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arm_q        <= 1'b0;
      addr_q       <= '0;
      start_q      <= '0;
      stop_q       <= '0;
      dec_q        <= '0;
      hold_q       <= '0;
      target_q     <= '0;
      cont_q       <= 1'b0;
      pass_cnt_q   <= '0;
      done_q       <= 1'b0;
      vld_pipe_q   <= '0;
      stb_pipe_q   <= '0;
      data_q       <= '0;
      sample_stb_q <= 1'b0;
    end else begin
      arm_q        <= arm_d;
      addr_q       <= addr_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      dec_q        <= dec_d;
      hold_q       <= hold_d;
      target_q     <= target_d;
      cont_q       <= cont_d;
      pass_cnt_q   <= pass_cnt_d;
      done_q       <= done_d;
      vld_pipe_q   <= vld_pipe_d;
      stb_pipe_q   <= stb_pipe_d;
      data_q       <= data_d;
      sample_stb_q <= sample_stb_d;
    end
  end

  // Output decode
  always_comb begin
    busy       = (state_q == S_ARMED) || (state_q == S_PLAY);
    bram_we    = 1'b0;
    bram_addr  = addr_q;
    data_o     = data_q;
    sample_stb = sample_stb_q;
    done       = done_q;
    pass_cnt   = pass_cnt_q;
  end

endmodule

// File: doc/bram_player.md
# bram_player

Multi-channel BRAM waveform player for the signal generator. It replaces the single-lane fixed-depth reader. It plays a configurable address window `[start_addr, stop_addr]` at a decimated rate, in one of three modes: single-shot, N repeats, or continuous. Playback starts after an arm/trigger handshake and can be aborted at any time. It sits between the waveform BRAM read port and the DAC output path, and drives each channel's idle level when it is not playing.

## Interface
- `ADDR_WIDTH`, 10, BRAM address width; window length is up to 2^ADDR_WIDTH.
- `DATA_WIDTH`, 14, sample width per channel.
- `N_CH`, 2, number of channel lanes sharing one address.
- `RD_LATENCY`, 1, BRAM read latency in cycles (1..4).

Ports:
- `clk` in 1: single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `arm` in 1: rising edge arms the player.
- `trig` in 1: level, sampled only while ARMED.
- `trig_sel` in 1: 0 = start immediately on arm; 1 = wait for `trig`=1.
- `abort` in 1: level; forces a return to IDLE.
- `mode` in 2: 0 single, 1 burst, 2 continuous, 3 reserved (treated as single).
- `burst_cnt` in 16: number of window passes in burst mode; 0 is treated as 1.
- `dec_rate` in 32: each address is held for `dec_rate`+1 cycles.
- `start_addr` in ADDR_WIDTH: first address of the window.
- `stop_addr` in ADDR_WIDTH: last address of the window (inclusive).
- `default_value` in N_CH*DATA_WIDTH: per-lane idle output; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- `bram_addr` out ADDR_WIDTH: read address.
- `bram_we` out 1: constant 0.
- `bram_data_i` in N_CH*DATA_WIDTH: packed lanes from the BRAM.
- `data_o` out N_CH*DATA_WIDTH: registered output lanes.
- `sample_stb` out 1: one-cycle pulse when `data_o` takes a new BRAM sample.
- `busy` out 1: high in ARMED or PLAY.
- `done` out 1: one-cycle pulse on normal completion.
- `pass_cnt` out 16: number of completed passes in the current run.

## Operation
- States:
  - IDLE → ARMED on the `arm` rising edge.
  - ARMED → PLAY when `trig_sel`=0, or when `trig`=1. The transition is taken in the first cycle of ARMED if the condition already holds.
  - PLAY → IDLE after the last hold of the last pass. `done` pulses in that cycle.
  - `abort`=1 in ARMED or PLAY → IDLE next cycle, with no `done`. `abort` has priority over the trigger and over completion.
- The `arm` edge detector register resets to 0. An `arm` held high through reset release therefore counts as an edge.
- On ARMED→PLAY, the player latches `mode`, `burst_cnt`, `dec_rate`, `start_addr` and `stop_addr`. Changing these inputs during PLAY has no effect.
- Window arithmetic is modulo 2^ADDR_WIDTH:
  - The address after `stop_addr` wraps to `start_addr`.
  - `stop_addr` < `start_addr` is legal and the window wraps through address 0.
  - `stop_addr`=`start_addr` gives a one-sample window.
- Pass accounting:
  - `pass_cnt` increments each time the address wraps from `stop_addr`.
  - Single mode ends after 1 pass; burst mode ends after `burst_cnt` passes.
  - In continuous mode, `pass_cnt` saturates at 0xFFFF and the player never completes.
- `pass_cnt` clears on entry to PLAY and holds its value in IDLE.
- `bram_addr` equals the latched `start_addr` in IDLE and ARMED.
- The output stream is delayed so that each address is paired with its own BRAM data:
  - A valid flag is delayed RD_LATENCY cycles relative to `bram_addr`.
  - When the delayed flag is 1, `data_o` <= `bram_data_i`; otherwise `data_o` <= `default_value`.
  - `sample_stb` marks the first registered cycle of each address's hold.
- Reset values: state IDLE, `bram_addr`=0, `data_o`=0, `sample_stb`=0, `busy`=0, `done`=0, `pass_cnt`=0, all counters 0. `default_value` appears on `data_o` from the first cycle after reset.

## Timing
- The arm edge is registered, so the `arm` rising edge at cycle t puts the player in ARMED at t+1.
- With `trig_sel`=0, the player enters PLAY at t+2. `bram_addr`=`start_addr` for the first hold.
- `bram_addr` advances every `dec_rate`+1 cycles.
- Latency from `bram_addr` to the matching `data_o` is RD_LATENCY+1 cycles.
- One pass of W addresses lasts W*(`dec_rate`+1) cycles.
- After the final hold, `busy` falls and `done` pulses in the same cycle. `data_o` returns to `default_value` RD_LATENCY+1 cycles later, after the last sample has drained.
- Abort: `busy`=0 the next cycle. Output lanes revert to `default_value` within RD_LATENCY+1 cycles.
- A new `arm` edge arriving in the same cycle as `done` is accepted and enters ARMED.
- `rst_n`=0 during PLAY returns every output to its reset value on the next edge.

## Test plan
- Single mode, start=4, stop=7, `dec_rate`=0, RD_LATENCY=1, `trig_sel`=0 → `bram_addr` sequence 4,5,6,7. `data_o` shows mem[4..7] starting 2 cycles after addr 4. `done` pulses once; `pass_cnt`=1.
- Burst mode, `burst_cnt`=3, start=1020, stop=2 (ADDR_WIDTH=10), `dec_rate`=2 → addresses 1020..1023,0,1,2, repeated 3 times. Each address is held 3 cycles, giving 63 PLAY cycles. `pass_cnt`=3; `sample_stb` count=21.
- `trig_sel`=1, `trig` asserted 50 cycles after `arm` → `busy`=1 from arm+1. `bram_addr` stays at start and `data_o` stays at default until the cycle after `trig`.
- Continuous mode with `abort` asserted after 1000 cycles → no `done`. `busy` falls 1 cycle after `abort`. Lanes return to per-lane `default_value` (e.g. 0x1FFF, 0x0000).
- `rst_n` low for 1 cycle mid-burst → all outputs at reset values. A fresh `arm` restarts with `pass_cnt`=0.
- Window with start=stop=9, `burst_cnt`=0 → exactly one address, one `sample_stb`, and `done` after `dec_rate`+1 cycles.
